control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter: RAM_RD_LATENCY, default 1, RAM read latency in cycles; legal range 1..3.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: decoded_instruction  input  decoded_instruction_type  current instruction class from datapath.
REQ-005 SHALL have ports: zero_op, neg_op, unsigned_overflow, signed_overflow  input  1 each  registered ALU flags from datapath.
REQ-006 SHALL have ports: branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable  output  1 each  datapath controls.
REQ-007 SHALL have port: operation  output  2  ALU select (00 add, 01 and, 10 or, 11 sub).
REQ-008 SHALL have ports: ram_write_enable  output  1  RAM write strobe; halt  output  1  processor stopped.

Function
REQ-009 SHALL implement states FETCH, DECODE, LOAD, STORE, ALU, BRANCH, HALT.
REQ-010 SHALL default every output to 0 in every state unless stated otherwise.
REQ-011 FETCH SHALL last RAM_RD_LATENCY+1 cycles with addr_sel=1, counted by an internal wait counter; ir_enable=1 only in the final cycle; then -> DECODE.
REQ-012 DECODE SHALL last 1 cycle and dispatch: I_LOAD->LOAD; I_STORE->STORE; I_MOVE/I_ADD/I_SUB/I_AND/I_OR->ALU; all branch classes and I_NOP->BRANCH; I_HALT->HALT.
REQ-013 LOAD SHALL last RAM_RD_LATENCY+1 cycles with addr_sel=0, c_sel=1; write_reg_enable=1 and pc_enable=1 only in the final cycle; then -> FETCH.
REQ-014 STORE SHALL last 1 cycle: addr_sel=0, ram_write_enable=1, pc_enable=1, branch=0; then -> FETCH.
REQ-015 ALU SHALL last 1 cycle: c_sel=0, write_reg_enable=1, pc_enable=1; operation = 00 ADD, 11 SUB, 01 AND, 10 OR, 01 MOVE; flags_reg_enable=1 except MOVE (0); then -> FETCH.
REQ-016 BRANCH SHALL last 1 cycle: pc_enable=1; branch=1 iff taken: BRANCH always; BZERO zero_op; BNZERO !zero_op; BNEG neg_op; BNNEG !neg_op; BOV signed_overflow; BNOV !signed_overflow; NOP never; then -> FETCH.
REQ-017 Branch conditions SHALL sample flags in the BRANCH cycle; flags written by the immediately preceding ALU instruction SHALL be visible.
REQ-018 HALT SHALL drive halt=1, all other outputs 0, and remain until rst.
REQ-019 pc_enable SHALL be asserted exactly once per executed instruction; the PC SHALL never advance in FETCH or DECODE.
REQ-020 ir_enable and write_reg_enable SHALL never be asserted in the same cycle; ram_write_enable SHALL only be asserted in STORE.
REQ-021 The wait counter SHALL reset to 0 on every entry into FETCH and LOAD.

Reset
REQ-022 rst=1 at a rising edge SHALL force FETCH with wait counter 0, in any state including mid-LOAD or HALT.
REQ-023 While rst=1 all outputs SHALL be 0; first FETCH cycle follows the first edge with rst=0.

Configuration
REQ-024 With CTRL_INSTR_COUNT_EN defined, SHALL add output instr_count[15:0], cleared by rst, incremented by 1 on each cycle with pc_enable=1, wrapping 0xFFFF->0x0000, frozen in HALT.
REQ-025 Without CTRL_INSTR_COUNT_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-026 decoded_instruction_type SHALL come from k_and_s_pkg; the state enum and ALU operation encodings SHALL also live in k_and_s_pkg.
REQ-027 SHALL be a single module with no sub-modules; a top module instantiates control_unit alongside datapath.

Verification
REQ-028 RAM_RD_LATENCY=1, I_ADD after reset -> FETCH 2 cycles (ir_enable in 2nd), DECODE, ALU with operation=00, write_reg_enable=1, flags_reg_enable=1, pc_enable=1; 4 cycles total.
REQ-029 RAM_RD_LATENCY=2, I_LOAD -> LOAD 3 cycles, c_sel=1 throughout, write_reg_enable=1 and pc_enable=1 only in 3rd.
REQ-030 I_BZERO with zero_op=1 -> branch=1, pc_enable=1; repeat with zero_op=0 -> branch=0, pc_enable=1.
REQ-031 I_MOVE -> operation=01, write_reg_enable=1, flags_reg_enable=0.
REQ-032 I_HALT -> halt=1 held 20 cycles, no pc_enable; rst=1 one cycle -> FETCH, halt=0.
REQ-033 CTRL_INSTR_COUNT_EN, 3 instructions (ADD, STORE, BNOV) -> instr_count=3; rst asserted mid-LOAD -> instr_count=0, state FETCH.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - instruction classes, controller state and ALU encodings shared by control_unit
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t S_FETCH  = 3'd0;
  localparam ctrl_state_t S_DECODE = 3'd1;
  localparam ctrl_state_t S_LOAD   = 3'd2;
  localparam ctrl_state_t S_STORE  = 3'd3;
  localparam ctrl_state_t S_ALU    = 3'd4;
  localparam ctrl_state_t S_BRANCH = 3'd5;
  localparam ctrl_state_t S_HALT   = 3'd6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  // MOVE passes its operand through the AND path
  function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
    case (instr)
      I_SUB:   return OP_SUB;
      I_AND:   return OP_AND;
      I_OR:    return OP_OR;
      I_MOVE:  return OP_AND;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic logic branch_taken(input decoded_instruction_type instr,
                                        input logic zero, input logic neg,
                                        input logic sovf);
    case (instr)
      I_BRANCH: return 1'b1;
      I_BZERO:  return zero;
      I_BNZERO: return !zero;
      I_BNEG:   return neg;
      I_BNNEG:  return !neg;
      I_BOV:    return sovf;
      I_BNOV:   return !sovf;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle processor controller FSM
// Optional CTRL_INSTR_COUNT_EN adds the instr_count retired-instruction counter.
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int RAM_RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic [1:0]              operation,
  output logic                    ram_write_enable,
`ifdef CTRL_INSTR_COUNT_EN
  output logic [15:0]             instr_count,
`endif
  output logic                    halt
);

  localparam logic [1:0] LAST_WAIT = 2'(RAM_RD_LATENCY);

  ctrl_state_t state, next_state;
  logic [1:0]  wait_cnt;
  logic        last_wait;
  logic        flags_unused;

  assign flags_unused = unsigned_overflow;
  assign last_wait    = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 2'd0;
    end else begin
      state <= next_state;
      // counter only runs while a multi-cycle state repeats; any transition clears it
      if ((state == S_FETCH || state == S_LOAD) && next_state == state)
        wait_cnt <= wait_cnt + 2'd1;
      else
        wait_cnt <= 2'd0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (last_wait) next_state = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                          next_state = S_LOAD;
          I_STORE:                         next_state = S_STORE;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR: next_state = S_ALU;
          I_HALT:                          next_state = S_HALT;
          default:                         next_state = S_BRANCH;
        endcase
      end
      S_LOAD:   if (last_wait) next_state = S_FETCH;
      S_STORE, S_ALU, S_BRANCH: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    operation        = OP_ADD;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          addr_sel  = 1'b1;
          ir_enable = last_wait;
        end
        S_LOAD: begin
          c_sel            = 1'b1;
          write_reg_enable = last_wait;
          pc_enable        = last_wait;
        end
        S_STORE: begin
          ram_write_enable = 1'b1;
          pc_enable        = 1'b1;
        end
        S_ALU: begin
          write_reg_enable = 1'b1;
          pc_enable        = 1'b1;
          flags_reg_enable = (decoded_instruction != I_MOVE);
          operation        = alu_op(decoded_instruction);
        end
        S_BRANCH: begin
          pc_enable = 1'b1;
          branch    = branch_taken(decoded_instruction, zero_op, neg_op, signed_overflow);
        end
        S_HALT:  halt = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CTRL_INSTR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      instr_count <= 16'd0;
    else if (pc_enable)
      instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit at read latencies 1 and 2
module tb_control_unit;
  import k_and_s_pkg::*;

  typedef struct {
    logic [10:0]             v;
    logic                    brq;
    logic                    hlt;
    decoded_instruction_type ins;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic zero_op = 1'b0, neg_op = 1'b0, uovf = 1'b0, sovf = 1'b0;
  decoded_instruction_type instr0 = I_NOP, instr1 = I_NOP;

  logic br0, pc0, ir0, as0, cs0, wr0, fr0, rw0, h0;
  logic br1, pc1, ir1, as1, cs1, wr1, fr1, rw1, h1;
  logic [1:0] op0, op1;
`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] count0, count1;
`endif

  always #5 clk = ~clk;

  control_unit #(.RAM_RD_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .decoded_instruction(instr0),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uovf), .signed_overflow(sovf),
    .branch(br0), .pc_enable(pc0), .ir_enable(ir0), .addr_sel(as0), .c_sel(cs0),
    .write_reg_enable(wr0), .flags_reg_enable(fr0), .operation(op0),
    .ram_write_enable(rw0),
`ifdef CTRL_INSTR_COUNT_EN
    .instr_count(count0),
`endif
    .halt(h0));

  control_unit #(.RAM_RD_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .decoded_instruction(instr1),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uovf), .signed_overflow(sovf),
    .branch(br1), .pc_enable(pc1), .ir_enable(ir1), .addr_sel(as1), .c_sel(cs1),
    .write_reg_enable(wr1), .flags_reg_enable(fr1), .operation(op1),
    .ram_write_enable(rw1),
`ifdef CTRL_INSTR_COUNT_EN
    .instr_count(count1),
`endif
    .halt(h1));

  // {branch, pc, ir, addr_sel, c_sel, wr_reg, flags_reg, op[1:0], ram_we, halt}
  logic [10:0] out0, out1;
  assign out0 = {br0, pc0, ir0, as0, cs0, wr0, fr0, op0, rw0, h0};
  assign out1 = {br1, pc1, ir1, as1, cs1, wr1, fr1, op1, rw1, h1};

  int n_checks = 0;
  int n_errors = 0;
  exp_t q0[$], q1[$];
  decoded_instruction_type script0[$], script1[$];
  logic [15:0] cnt0 = 16'd0, cnt1 = 16'd0;
  logic [10:0] log0 [64];
  logic [10:0] log1 [64];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int d, input logic [10:0] v, input logic brq,
                               input logic hlt, input decoded_instruction_type ins);
    exp_t e;
    e.v = v; e.brq = brq; e.hlt = hlt; e.ins = ins;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  // Whole-instruction schedule: fetch, decode, then the execute phase
  function automatic void build(input int d, input decoded_instruction_type ins, input int lat);
    for (int i = 0; i <= lat; i++) push(d, (i == lat) ? 11'h180 : 11'h080, 1'b0, 1'b0, ins);
    push(d, 11'h000, 1'b0, 1'b0, ins);
    case (ins)
      I_LOAD:  for (int i = 0; i <= lat; i++) push(d, (i == lat) ? 11'h260 : 11'h040, 1'b0, 1'b0, ins);
      I_STORE: push(d, 11'h202, 1'b0, 1'b0, ins);
      I_ADD:   push(d, 11'h230, 1'b0, 1'b0, ins);
      I_SUB:   push(d, 11'h23C, 1'b0, 1'b0, ins);
      I_AND:   push(d, 11'h234, 1'b0, 1'b0, ins);
      I_OR:    push(d, 11'h238, 1'b0, 1'b0, ins);
      I_MOVE:  push(d, 11'h224, 1'b0, 1'b0, ins);
      I_HALT:  push(d, 11'h001, 1'b0, 1'b1, ins);
      default: push(d, 11'h200, 1'b1, 1'b0, ins);
    endcase
  endfunction

  function automatic logic [10:0] resolve(input exp_t e);
    logic t;
    case (e.ins)
      I_BRANCH: t = 1'b1;
      I_BZERO:  t = zero_op;
      I_BNZERO: t = !zero_op;
      I_BNEG:   t = neg_op;
      I_BNNEG:  t = !neg_op;
      I_BOV:    t = sovf;
      I_BNOV:   t = !sovf;
      default:  t = 1'b0;
    endcase
    return (e.brq && t) ? (e.v | 11'h400) : e.v;
  endfunction

  function automatic decoded_instruction_type pick(input int d);
    if (d == 0 && script0.size() > 0) return script0.pop_front();
    if (d == 1 && script1.size() > 0) return script1.pop_front();
    return decoded_instruction_type'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [10:0] e0, e1;
    script0 = '{I_ADD, I_MOVE, I_BZERO, I_BZERO, I_HALT};
    script1 = '{I_LOAD, I_HALT};
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (n < 64) begin
        rst     = (n < 3) || (n == 51);
        zero_op = (n - 3 < 12);
      end else begin
        rst     = ($urandom_range(0, 29) == 0);
        zero_op = $urandom_range(0, 1) == 1;
      end
      neg_op = $urandom_range(0, 1) == 1;
      sovf   = $urandom_range(0, 1) == 1;
      uovf   = $urandom_range(0, 1) == 1;
      if (!rst && q0.size() == 0) begin instr0 = pick(0); build(0, instr0, 1); end
      if (!rst && q1.size() == 0) begin instr1 = pick(1); build(1, instr1, 2); end

      @(negedge clk);
      e0 = (rst || q0.size() == 0) ? 11'h000 : resolve(q0[0]);
      e1 = (rst || q1.size() == 0) ? 11'h000 : resolve(q1[0]);
      chk("lat1_outputs", {5'd0, out0}, {5'd0, e0});
      chk("lat2_outputs", {5'd0, out1}, {5'd0, e1});
`ifdef CTRL_INSTR_COUNT_EN
      chk("lat1_instr_count", count0, cnt0);
      chk("lat2_instr_count", count1, cnt1);
`endif
      if (n < 64) begin log0[n] = out0; log1[n] = out1; end

      if (rst) begin
        q0.delete(); q1.delete(); cnt0 = 16'd0; cnt1 = 16'd0;
      end else begin
        if (q0.size() > 0) begin
          if (q0[0].v[9]) cnt0++;
          if (!q0[0].hlt) void'(q0.pop_front());
        end
        if (q1.size() > 0) begin
          if (q1[0].v[9]) cnt1++;
          if (!q1[0].hlt) void'(q1.pop_front());
        end
      end
    end

    chk("reset_outputs_zero", {5'd0, log0[0]}, 16'h000);
    chk("add_fetch1",         {5'd0, log0[3]}, 16'h080);
    chk("add_fetch2_ir",      {5'd0, log0[4]}, 16'h180);
    chk("add_decode",         {5'd0, log0[5]}, 16'h000);
    chk("add_alu",            {5'd0, log0[6]}, 16'h230);
    chk("move_alu",           {5'd0, log0[10]}, 16'h224);
    chk("bzero_taken",        {5'd0, log0[14]}, 16'h600);
    chk("bzero_not_taken",    {5'd0, log0[18]}, 16'h200);
    chk("load_lat2_c1",       {5'd0, log1[7]}, 16'h040);
    chk("load_lat2_c2",       {5'd0, log1[8]}, 16'h040);
    chk("load_lat2_c3",       {5'd0, log1[9]}, 16'h260);
    for (int i = 22; i < 51; i++) chk("halt_held", {5'd0, log0[i]}, 16'h001);
    chk("halt_rst_cycle",     {5'd0, log0[51]}, 16'h000);
    chk("halt_rst_fetch",     {5'd0, log0[52]}, 16'h080);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
